// File: rtl/sdp_ram_rd_stream.sv
// sdp_ram_rd_stream: burst reader from SDP RAM port B into a valid/ready stream with a 2-entry skid FIFO.
// Defining SDP_RD_STREAM_CNT_EN adds the saturating stat_beats handshake counter.
module sdp_ram_rd_stream #(
  parameter int MEM_DATAWIDTH = 128,
  parameter int MEM_ADDRWIDTH = 14
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [MEM_ADDRWIDTH-1:0] req_addr,
  input  logic [MEM_ADDRWIDTH:0]   req_len,
  output logic                     ram_enb,
  output logic [MEM_ADDRWIDTH-1:0] ram_addrb,
  input  logic [MEM_DATAWIDTH-1:0] ram_doutb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MEM_DATAWIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
`ifdef SDP_RD_STREAM_CNT_EN
  output logic [31:0]              stat_beats,
`endif
  output logic                     done
);
  localparam int LENW = MEM_ADDRWIDTH + 1;
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [MEM_ADDRWIDTH-1:0] addr;
  logic [LENW-1:0] remaining;
  logic inflight, inflight_last;
  logic [MEM_DATAWIDTH-1:0] fifo_data [2];
  logic [1:0] fifo_last;
  logic wp, rp;
  logic [1:0] count;
  logic accept, pop, issue, push_f, pop_f, final_issue;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = req_valid & req_ready;
  assign out_valid = (count != 2'd0) | inflight;
  assign out_data = (count != 2'd0) ? fifo_data[rp] : inflight ? ram_doutb : '0;
  assign out_last = (count != 2'd0) ? fifo_last[rp] : inflight & inflight_last;
  assign pop = out_valid & out_ready;
  // a word arriving from the RAM bypasses the FIFO when it is empty and the sink takes it
  assign push_f = inflight & ~((count == 2'd0) & pop);
  assign pop_f = pop & (count != 2'd0);
  assign issue = (state == READ) && (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign final_issue = issue && (remaining == LENW'(1));
  assign ram_enb = issue;
  assign ram_addrb = addr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
      done <= 1'b0;
    end else begin
      done <= (accept && req_len == '0) || (state == DRAIN && pop && out_last);
      if (accept && req_len != '0) begin
        addr <= req_addr;
        remaining <= req_len;
        state <= READ;
      end
      if (issue) begin
        addr <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (final_issue) state <= DRAIN;
      if (state == DRAIN && pop && out_last) state <= IDLE;
      inflight <= issue;
      inflight_last <= final_issue;
      if (push_f) begin
        fifo_data[wp] <= ram_doutb;
        fifo_last[wp] <= inflight_last;
        wp <= ~wp;
      end
      if (pop_f) rp <= ~rp;
      count <= count + 2'(push_f) - 2'(pop_f);
    end
`ifdef SDP_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stat_beats <= '0;
    else if (pop && stat_beats != '1) stat_beats <= stat_beats + 1'b1;
`endif
endmodule
